wdt_power_control: RTL and testbench

Watchdog timer and sleep/power-down controller for the PIC16F core, directly upstream of the STATUS register. Produces the read-only TO/PD status bits and a write strobe the STATUS write mux uses to load bits 4:3. Counts WDT ticks through an optional prescaler, resets the core on timeout while awake, and wakes the core on timeout or interrupt while sleeping.

---
 rtl/wdt_power_control.sv | 149 ++++++++++++++
 tb/tb_wdt_power_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wdt_power_control.sv
// Watchdog timer plus sleep/power-down controller feeding the STATUS TO/PD bits.
// Optional prescaler enabled by defining WDT_PRESCALER_EN.
module wdt_power_control #(
  parameter int unsigned WDT_W = 8,
  parameter int unsigned PS_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wdt_en,
  input  logic             clrwdt,
  input  logic             sleep,
  input  logic             wake_irq,
  input  logic             psa,
  input  logic [PS_W-1:0]  ps,
  output logic             n_to,
  output logic             n_pd,
  output logic             to_pd_wr,
  output logic             asleep,
  output logic             wdt_reset,
  output logic             wdt_wake,
  output logic [WDT_W-1:0] wdt_count
);

  typedef enum logic [0:0] {StAwake, StAsleep} state_e;

  state_e           state_q, state_d;
  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             n_to_q, n_to_d;
  logic             n_pd_q, n_pd_d;
  logic             wr_q, wr_d;
  logic             reset_q, reset_d;
  logic             wake_q, wake_d;
  logic             tick;
  logic             timeout;
  logic             clr_cnt;

`ifdef WDT_PRESCALER_EN
  localparam int unsigned PreW = (2 ** PS_W) - 1;

  logic [PreW-1:0] pre_q, pre_d;
  logic [PreW-1:0] ps_mask;

  // Low ps bits all ones marks the last cycle of each 2^ps window.
  assign ps_mask = ~({PreW{1'b1}} << ps);
  assign tick    = !psa || ((pre_q & ps_mask) == ps_mask);

  always_comb begin
    pre_d = pre_q + PreW'(1);
    if (!wdt_en || clr_cnt) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  logic unused_ps_cfg;
  assign unused_ps_cfg = ^{psa, ps};
  assign tick          = 1'b1;
`endif

  assign timeout = wdt_en && tick && (&cnt_q);

  always_comb begin
    state_d = state_q;
    n_to_d  = n_to_q;
    n_pd_d  = n_pd_q;
    wr_d    = 1'b0;
    reset_d = 1'b0;
    wake_d  = 1'b0;
    clr_cnt = 1'b0;

    unique case (state_q)
      StAwake: begin
        if (sleep) begin
          clr_cnt = 1'b1;
          n_to_d  = 1'b1;
          n_pd_d  = 1'b0;
          wr_d    = 1'b1;
          state_d = StAsleep;
        end else if (clrwdt) begin
          clr_cnt = 1'b1;
          n_to_d  = 1'b1;
          n_pd_d  = 1'b1;
          wr_d    = 1'b1;
        end else if (timeout) begin
          reset_d = 1'b1;
          n_to_d  = 1'b0;
          n_pd_d  = 1'b1;
          wr_d    = 1'b1;
        end
      end
      StAsleep: begin
        if (timeout) begin
          wake_d  = 1'b1;
          n_to_d  = 1'b0;
          n_pd_d  = 1'b0;
          wr_d    = 1'b1;
          state_d = StAwake;
        end else if (wake_irq) begin
          wake_d  = 1'b1;
          state_d = StAwake;
        end
      end
      default: state_d = StAwake;
    endcase

    cnt_d = cnt_q;
    if (!wdt_en || clr_cnt) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + WDT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAwake;
      cnt_q   <= '0;
      n_to_q  <= 1'b1;
      n_pd_q  <= 1'b1;
      wr_q    <= 1'b1;
      reset_q <= 1'b0;
      wake_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_to_q  <= n_to_d;
      n_pd_q  <= n_pd_d;
      wr_q    <= wr_d;
      reset_q <= reset_d;
      wake_q  <= wake_d;
    end
  end

  assign n_to      = n_to_q;
  assign n_pd      = n_pd_q;
  assign to_pd_wr  = wr_q;
  assign asleep    = (state_q == StAsleep);
  assign wdt_reset = reset_q;
  assign wdt_wake  = wake_q;
  assign wdt_count = cnt_q;

endmodule

// File: tb/tb_wdt_power_control.sv
// Directed bench for wdt_power_control: timeouts, CLRWDT, sleep/wake and WDT disable.
module tb_wdt_power_control;

  logic       clk = 1'b0;
  logic       rst, wdt_en, clrwdt, sleep, wake_irq, psa;
  logic [2:0] ps;
  logic       n_to, n_pd, to_pd_wr, asleep, wdt_reset, wdt_wake;
  logic [7:0] wdt_count;

  int checks = 0;
  int passes = 0;
  int n_rst_seen, n_wake_seen, n_wr_seen;

  wdt_power_control #(.WDT_W(8), .PS_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .wdt_en    (wdt_en),
    .clrwdt    (clrwdt),
    .sleep     (sleep),
    .wake_irq  (wake_irq),
    .psa       (psa),
    .ps        (ps),
    .n_to      (n_to),
    .n_pd      (n_pd),
    .to_pd_wr  (to_pd_wr),
    .asleep    (asleep),
    .wdt_reset (wdt_reset),
    .wdt_wake  (wdt_wake),
    .wdt_count (wdt_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n cycles, tallying pulse outputs sampled after each edge.
  task automatic run(input int n);
    n_rst_seen  = 0;
    n_wake_seen = 0;
    n_wr_seen   = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (wdt_reset === 1'b1) n_rst_seen++;
      if (wdt_wake === 1'b1) n_wake_seen++;
      if (to_pd_wr === 1'b1) n_wr_seen++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_bits(input string tag, input logic [3:0] exp_to_pd_wr_as);
    check({tag, ".n_to"}, 32'(n_to), 32'(exp_to_pd_wr_as[3]));
    check({tag, ".n_pd"}, 32'(n_pd), 32'(exp_to_pd_wr_as[2]));
    check({tag, ".to_pd_wr"}, 32'(to_pd_wr), 32'(exp_to_pd_wr_as[1]));
    check({tag, ".asleep"}, 32'(asleep), 32'(exp_to_pd_wr_as[0]));
  endtask

  initial begin
    rst = 1'b1; wdt_en = 1'b1; clrwdt = 1'b0; sleep = 1'b0; wake_irq = 1'b0;
    psa = 1'b0; ps = 3'd0;

    // Reset values
    step();
    step();
    check_bits("rst", 4'b1110);
    check("rst.wdt_reset", 32'(wdt_reset), 32'd0);
    check("rst.wdt_wake", 32'(wdt_wake), 32'd0);
    check("rst.count", 32'(wdt_count), 32'd0);
    rst = 1'b0;

    // Free-running timeout on the 256th edge after release
    run(255);
    check("to1.count255", 32'(wdt_count), 32'd255);
    check("to1.no_early_rst", 32'(n_rst_seen), 32'd0);
    check("to1.no_wr", 32'(n_wr_seen), 32'd0);
    step();
    check("to1.wdt_reset", 32'(wdt_reset), 32'd1);
    check_bits("to1", 4'b0110);
    check("to1.count_wrap", 32'(wdt_count), 32'd0);
    step();
    check("to1.reset_1cyc", 32'(wdt_reset), 32'd0);
    check("to1.wr_1cyc", 32'(to_pd_wr), 32'd0);

    // CLRWDT exactly when count would wrap
    run(254);
    check("clr.count255", 32'(wdt_count), 32'd255);
    clrwdt = 1'b1;
    step();
    clrwdt = 1'b0;
    check("clr.no_reset", 32'(wdt_reset), 32'd0);
    check("clr.count", 32'(wdt_count), 32'd0);
    check_bits("clr", 4'b1110);

    // Sleep then WDT timeout wakes
    sleep = 1'b1;
    step();
    sleep = 1'b0;
    check_bits("slp", 4'b1011);
    check("slp.count", 32'(wdt_count), 32'd0);
    run(255);
    check("slp.count255", 32'(wdt_count), 32'd255);
    check("slp.still_asleep", 32'(asleep), 32'd1);
    check("slp.no_wake", 32'(n_wake_seen), 32'd0);
    step();
    check("slp.wdt_wake", 32'(wdt_wake), 32'd1);
    check("slp.no_reset", 32'(wdt_reset), 32'd0);
    check_bits("slp.to", 4'b0010);
    step();
    check("slp.wake_1cyc", 32'(wdt_wake), 32'd0);

    // Sleep, ignored CLRWDT, then wake_irq
    sleep = 1'b1;
    step();
    sleep = 1'b0;
    clrwdt = 1'b1;
    step();
    clrwdt = 1'b0;
    check("irq.clr_ignored_count", 32'(wdt_count), 32'd1);
    check_bits("irq.clr_ignored", 4'b1001);
    run(8);
    wake_irq = 1'b1;
    step();
    wake_irq = 1'b0;
    check("irq.wdt_wake", 32'(wdt_wake), 32'd1);
    check_bits("irq", 4'b1000);
    check("irq.count", 32'(wdt_count), 32'd10);

    psa = 1'b1;
    ps  = 3'd2;
    clrwdt = 1'b1;
    step();
    clrwdt = 1'b0;
`ifdef WDT_PRESCALER_EN
    // Divide-by-4: CLRWDT at 1000 restarts a 1024-cycle window
    run(999);
    check("ps.count", 32'(wdt_count), 32'd249);
    check("ps.no_reset", 32'(n_rst_seen), 32'd0);
    clrwdt = 1'b1;
    step();
    clrwdt = 1'b0;
    check_bits("ps.clr", 4'b1110);
    run(1023);
    check("ps.count255", 32'(wdt_count), 32'd255);
    check("ps.no_early_rst", 32'(n_rst_seen), 32'd0);
    step();
    check("ps.wdt_reset", 32'(wdt_reset), 32'd1);
    check_bits("ps.to", 4'b0110);
`else
    // Without the prescaler psa/ps have no effect
    run(255);
    check("nops.count255", 32'(wdt_count), 32'd255);
    check("nops.no_early_rst", 32'(n_rst_seen), 32'd0);
    step();
    check("nops.wdt_reset", 32'(wdt_reset), 32'd1);
    check_bits("nops.to", 4'b0110);
`endif
    psa = 1'b0;
    ps  = 3'd0;

    // WDT disabled: no pulses, counter parked
    wdt_en = 1'b0;
    run(2000);
    check("dis.resets", 32'(n_rst_seen), 32'd0);
    check("dis.wakes", 32'(n_wake_seen), 32'd0);
    check("dis.wr", 32'(n_wr_seen), 32'd0);
    check("dis.count", 32'(wdt_count), 32'd0);
    sleep = 1'b1;
    step();
    sleep = 1'b0;
    run(300);
    check("dis.asleep", 32'(asleep), 32'd1);
    check("dis.no_wake", 32'(n_wake_seen), 32'd0);

    // rst while asleep
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_bits("rst_slp", 4'b1110);
    check("rst_slp.no_wake", 32'(wdt_wake), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
